// File: rtl/ppa_pkg.sv
// ppa_pkg: shared types and helpers for the pipelined Kogge-Stone adder
//   pg_t            generate/propagate pair for one prefix node
//   clog2_ceil      ceil(log2(v))
//   num_stages      prefix pipeline stages for a width and register spacing
//   pg_combine      prefix operator: G = Gh | (Ph & Gl), P = Ph & Pl
package ppa_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    function automatic int clog2_ceil(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int num_stages(input int width, input int reg_every);
        return (clog2_ceil(width) + reg_every - 1) / reg_every;
    endfunction

    function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
        return '{g: hi.g | (hi.p & lo.g), p: hi.p & lo.p};
    endfunction

endpackage

// File: rtl/ppa_black_cell.sv
// ppa_black_cell: single Kogge-Stone prefix node
//   hi  in   pg pair of the more significant span
//   lo  in   pg pair of the less significant span
//   o   out  combined pg pair
module ppa_black_cell
    import ppa_pkg::*;
(
    input  pg_t hi,
    input  pg_t lo,
    output pg_t o
);
    assign o = pg_combine(hi, lo);
endmodule

// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: pipelined Kogge-Stone adder/subtractor with valid/ready on both sides
//   clk, rst_n (sync, active-low)
//   in_valid/in_ready, in_a, in_b, in_cin, in_sub, in_tag       operation input
//   out_valid/out_ready, out_sum, out_cout, out_ovf, out_zero, out_tag   result output
//   in_sat (only with PPA_SATURATE_EN defined): clamp sum on signed overflow
module pipelined_prefix_adder
    import ppa_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
`ifdef PPA_SATURATE_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int L = clog2_ceil(WIDTH);
    localparam int N = num_stages(WIDTH, REG_EVERY);

    logic [N:0]       v;
    logic [N:0]       ld;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             c0_q;
    logic [TAG_W-1:0] tag0;
    logic             sat0;
    logic             sat_i;
    pg_t              init [0:WIDTH];
    pg_t              fin  [0:WIDTH];
    logic [WIDTH-1:0] p_fin;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] res;
    logic [TAG_W-1:0] tag_fin;
    logic             sat_fin;
    logic             cout_w;
    logic             ovf_w;

`ifdef PPA_SATURATE_EN
    assign sat_i = in_sat;
`else
    assign sat_i = 1'b0;
`endif

    // A stage can load when it or any stage downstream of it is empty, or the output drains.
    for (genvar k = 0; k <= N; k++) begin : g_ld
        assign ld[k] = out_ready || !(&v[N:k]);
    end

    assign in_ready  = ld[0];
    assign out_valid = v[N];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v        <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
            out_tag  <= '0;
        end else begin
            if (ld[0]) v[0] <= in_valid;
            for (int k = 1; k <= N; k++) if (ld[k]) v[k] <= v[k-1];
            if (ld[N] && v[N-1]) begin
                out_sum  <= res;
                out_cout <= cout_w;
                out_ovf  <= ovf_w;
                out_zero <= ~|res;
                out_tag  <= tag_fin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld[0] && in_valid) begin
            a_q  <= in_a;
            b_q  <= in_sub ? ~in_b : in_b;
            c0_q <= in_sub | in_cin;
            tag0 <= in_tag;
            sat0 <= sat_i;
        end
    end

    // Index 0 is the carry-in as a bit -1 generate; index i+1 is operand bit i.
    always_comb begin
        init[0] = '{g: c0_q, p: 1'b0};
        for (int i = 0; i < WIDTH; i++) init[i+1] = '{g: a_q[i] & b_q[i], p: a_q[i] ^ b_q[i]};
    end

    for (genvar l = 0; l < L; l++) begin : g_lvl
        pg_t src [0:WIDTH];
        pg_t nxt [0:WIDTH];
        if (l == 0) begin : g_src
            assign src = init;
        end else if (l % REG_EVERY == 0) begin : g_src
            assign src = g_stg[l / REG_EVERY].pg_r;
        end else begin : g_src
            assign src = g_lvl[l-1].nxt;
        end
        for (genvar i = 0; i <= WIDTH; i++) begin : g_node
            if (i >= (1 << l)) begin : g_bc
                ppa_black_cell u_bc (.hi(src[i]), .lo(src[i - (1 << l)]), .o(nxt[i]));
            end else begin : g_pass
                assign nxt[i] = src[i];
            end
        end
    end

    for (genvar s = 1; s < N; s++) begin : g_stg
        pg_t              pg_r [0:WIDTH];
        logic [WIDTH-1:0] p_r;
        logic [TAG_W-1:0] tag_r;
        logic             sat_r;
        logic [WIDTH-1:0] p_in;
        logic [TAG_W-1:0] tag_in;
        logic             sat_in;
        if (s == 1) begin : g_in
            assign p_in   = a_q ^ b_q;
            assign tag_in = tag0;
            assign sat_in = sat0;
        end else begin : g_in
            assign p_in   = g_stg[s-1].p_r;
            assign tag_in = g_stg[s-1].tag_r;
            assign sat_in = g_stg[s-1].sat_r;
        end
        always_ff @(posedge clk) begin
            if (ld[s] && v[s-1]) begin
                pg_r  <= g_lvl[s*REG_EVERY-1].nxt;
                p_r   <= p_in;
                tag_r <= tag_in;
                sat_r <= sat_in;
            end
        end
    end

    if (N == 1) begin : g_fin
        assign p_fin   = a_q ^ b_q;
        assign tag_fin = tag0;
        assign sat_fin = sat0;
    end else begin : g_fin
        assign p_fin   = g_stg[N-1].p_r;
        assign tag_fin = g_stg[N-1].tag_r;
        assign sat_fin = g_stg[N-1].sat_r;
    end

    // fin[j] spans bits -1..j-1, i.e. the carry into bit j; fin[WIDTH] spans bits 0..WIDTH-1 only.
    assign fin = g_lvl[L-1].nxt;

    always_comb begin
        for (int j = 0; j < WIDTH; j++) carry[j] = fin[j].g;
    end

    assign sum_w  = p_fin ^ carry;
    assign cout_w = fin[WIDTH].g | (fin[WIDTH].p & fin[0].g);
    assign ovf_w  = carry[WIDTH-1] ^ cout_w;
    // Wrapped MSB 1 means positive overflow (clamp to max), MSB 0 means negative (clamp to min).
    assign res    = (sat_fin && ovf_w) ? {~sum_w[WIDTH-1], {(WIDTH-1){sum_w[WIDTH-1]}}} : sum_w;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// tb_pipelined_prefix_adder: self-checking bench for pipelined_prefix_adder (WIDTH 32, REG_EVERY 2)
//   directed vector table, pipeline sequences, and a randomized scoreboard run;
//   saturation vectors are added when PPA_SATURATE_EN is defined
module tb_pipelined_prefix_adder;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic        sat;
        logic [3:0]  tag;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic [3:0]  tag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic [3:0]  in_tag;
    logic        in_sat;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;
    logic [3:0]  out_tag;

    int   checks;
    int   errors;
    int   n_acc;
    exp_t q[$];
    vec_t vt[$];
    logic held_valid;
    exp_t held;

    pipelined_prefix_adder #(.WIDTH(32), .REG_EVERY(2), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
`ifdef PPA_SATURATE_EN
        .in_sat(in_sat),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_tag(out_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, act, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                   input logic sub, input logic sat, input logic [3:0] tag);
        exp_t e;
        longint sa, sb, sr, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sr = sub ? sa - sb : sa + sb + longint'(cin);
        e.sum  = sr[31:0];
        e.cout = sub ? (ua >= ub) : ((ua + ub + longint'(cin)) > 64'sd4294967295);
        e.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        if (sat && e.ovf) e.sum = (sr > 0) ? 32'h7FFFFFFF : 32'h80000000;
        e.zero = (e.sum == 32'd0);
        e.tag  = tag;
        return e;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
        held_valid = 1'b0;
    endtask

    // One cycle with scoreboard: inputs already set; sample at posedge+3 then advance.
    task automatic tick();
        #2;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_out", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_sum", out_sum, e.sum);
                chk("sb_cout", out_cout, e.cout);
                chk("sb_ovf", out_ovf, e.ovf);
                chk("sb_zero", out_zero, e.zero);
                chk("sb_tag", out_tag, e.tag);
            end
        end
        if (out_valid && !out_ready && held_valid) begin
            chk("stall_sum", out_sum, held.sum);
            chk("stall_flags", {out_cout, out_ovf, out_zero}, {held.cout, held.ovf, held.zero});
            chk("stall_tag", out_tag, held.tag);
        end
        held_valid = out_valid && !out_ready;
        held = '{sum: out_sum, cout: out_cout, ovf: out_ovf, zero: out_zero, tag: out_tag};
        if (in_valid && in_ready) begin
            q.push_back(model(in_a, in_b, in_cin, in_sub, in_sat, in_tag));
            n_acc++;
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        int lat;
        string nm;
        nm = $sformatf("vec%0d", idx);
        in_valid = 1'b1; in_a = t.a; in_b = t.b; in_cin = t.cin; in_sub = t.sub;
        in_sat = t.sat; in_tag = t.tag; out_ready = 1'b1;
        #2;
        chk({nm, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, 4);
        chk({nm, "_sum"}, out_sum, t.sum);
        chk({nm, "_cout"}, out_cout, t.cout);
        chk({nm, "_ovf"}, out_ovf, t.ovf);
        chk({nm, "_zero"}, out_zero, t.zero);
        chk({nm, "_tag"}, out_tag, t.tag);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h00000000;
            1: return 32'hFFFFFFFF;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        checks = 0; errors = 0; n_acc = 0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        in_tag = '0; in_sat = 1'b0; out_ready = 1'b1; held_valid = 1'b0;
        held = '{sum: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b0, tag: '0};

        do_reset();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_outputs", {out_sum, out_cout, out_ovf, out_zero, out_tag}, '0);

        //        a             b             cin   sub   sat   tag   sum           cout  ovf   zero
        vt.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 4'd3, 32'h00000000, 1'b1, 1'b0, 1'b1});
        vt.push_back('{32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 4'd5, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0});
        vt.push_back('{32'h00000005, 32'h00000003, 1'b0, 1'b1, 1'b0, 4'd1, 32'h00000002, 1'b1, 1'b0, 1'b0});
        vt.push_back('{32'h00000003, 32'h00000005, 1'b0, 1'b1, 1'b0, 4'd2, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0});
        vt.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 4'd4, 32'h80000000, 1'b0, 1'b1, 1'b0});
        vt.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 4'd6, 32'h00000000, 1'b1, 1'b1, 1'b1});
        vt.push_back('{32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0, 4'd7, 32'h00000003, 1'b0, 1'b0, 1'b0});
        vt.push_back('{32'h00000005, 32'h00000005, 1'b1, 1'b1, 1'b0, 4'd8, 32'h00000000, 1'b1, 1'b0, 1'b1});
        vt.push_back('{32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 4'd9, 32'h00000000, 1'b1, 1'b0, 1'b1});
        vt.push_back('{32'h12345678, 32'h0FEDCBA8, 1'b0, 1'b0, 1'b0, 4'hA, 32'h22222220, 1'b0, 1'b0, 1'b0});
`ifdef PPA_SATURATE_EN
        vt.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 4'hB, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0});
        vt.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 4'hC, 32'h80000000, 1'b0, 1'b1, 1'b0});
        vt.push_back('{32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1, 4'hD, 32'h80000000, 1'b1, 1'b1, 1'b0});
`endif
        for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);
        in_sat = 1'b0;

        // Back-to-back stream: results in cycles 4..11, in order.
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 8);
            in_a = 32'(c); in_b = 32'(c); in_cin = 1'b0; in_sub = 1'b0; in_tag = 4'(c);
            #2;
            if (c < 8) chk("b2b_in_ready", in_ready, 1'b1);
            chk("b2b_out_valid", out_valid, (c >= 4 && c < 12));
            if (c >= 4 && c < 12) begin
                chk("b2b_sum", out_sum, 32'(2 * (c - 4)));
                chk("b2b_tag", out_tag, 4'(c - 4));
            end
            @(posedge clk); #1;
        end

        // Backpressure: capacity 4, stable stalled outputs, in-order release.
        do_reset();
        n_acc = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_cin = 1'(c);
            in_sub = 1'($urandom); in_tag = 4'(c);
            tick();
        end
        chk("bp_capacity", n_acc, 4);
        #2;
        chk("bp_in_ready_low", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 40 && n_acc < 12; c++) begin
            in_valid = 1'b1; in_a = pick(); in_b = pick(); in_cin = 1'($urandom);
            in_sub = 1'($urandom); in_tag = 4'($urandom);
            tick();
        end
        chk("bp_resume_accepts", n_acc, 12);
        drain();

        // Reset with three operations in flight.
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_a = 32'(c + 1); in_b = 32'd1; in_cin = 1'b0;
            in_sub = 1'b0; in_tag = 4'(c + 1);
            tick();
        end
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_outputs", {out_sum, out_cout, out_ovf, out_zero, out_tag}, '0);
        chk("midrst_in_ready", in_ready, 1'b1);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 8; c++) begin
                #2;
                if (out_valid) seen++;
                @(posedge clk); #1;
            end
            chk("midrst_no_output", seen, 0);
        end

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            in_a = pick(); in_b = pick(); in_cin = 1'($urandom); in_sub = 1'($urandom);
            in_tag = 4'($urandom);
`ifdef PPA_SATURATE_EN
            in_sat = 1'($urandom);
`endif
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_prefix_adder.md
Name: pipelined_prefix_adder

Overview:
Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor with valid/ready handshakes on both sides. It is the next-generation adder for the project datapath: generic width, selectable register spacing in the prefix tree, add/sub mode, status flags and a pass-through tag. It sits between an operand-issue stage and a result-writeback consumer that can apply backpressure.

Parameters:
WIDTH, 32, operand width; power of two, 4..64.
REG_EVERY, 2, prefix levels per pipeline register; 1..log2(WIDTH).
TAG_W, 4, width of the opaque tag carried alongside each operation; at least 1.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operation offered
in_ready  out  1  adder accepts this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_cin  in  1  carry-in (add mode only)
in_sub  in  1  1 = A - B
in_tag  in  TAG_W  tag, returned unchanged
out_valid  out  1  result available
out_ready  in  1  consumer accepts
out_sum  out  WIDTH  result
out_cout  out  1  carry out; in sub mode 1 = no borrow
out_ovf  out  1  signed overflow
out_zero  out  1  out_sum == 0
out_tag  out  TAG_W  tag of this result

Behaviour:
- One clock. Reset is synchronous and active-low on rst_n. Reset clears all stage valid bits, out_valid, out_sum, out_cout, out_ovf, out_zero and out_tag to 0. in_ready is 1 in the first cycle after reset is released.
- Transfer occurs when valid && ready on the same edge.
- Stages:
  - S0 registers the effective operands: b_eff = in_sub ? ~in_b : in_b; c0 = in_sub ? 1 : in_cin. In sub mode in_cin is ignored.
  - S1..SN each apply up to REG_EVERY Kogge-Stone levels, then register the result. N = ceil(log2(WIDTH)/REG_EVERY).
  - Per-bit terms: g = a & b_eff; p = a ^ b_eff. Combine operator: G = Gh | (Ph & Gl), P = Ph & Pl. c0 is folded in as a bit -1 generate.
  - SN also forms out_sum = p ^ carry_in_per_bit, out_cout = carry out of the MSB, out_ovf = carry into MSB ^ carry out of MSB, and out_zero. The SN register drives the output ports.
- Latency LAT = 1 + N cycles from accept to out_valid, when there is no stall. Defaults: N = 3, LAT = 4.
- Throughput is one operation per cycle with out_ready held high.
- Backpressure is bubble-collapsing:
  - Stage k loads when it is empty or its contents advance this cycle.
  - in_ready = !v0 || S0 advances, combinational through the chain to out_ready.
  - Capacity is exactly LAT operations. With out_ready low, in_ready drops once LAT operations are held.
- Stalled outputs: while out_valid && !out_ready, out_sum, out_cout, out_ovf, out_zero and out_tag hold stable.
- Ordering: results leave strictly in accept order. No reordering and no drops.
- Reset mid-operation discards every in-flight operation. No output transfer occurs for any of them.
- Arithmetic wraps modulo 2^WIDTH. Flags are valid only while out_valid is 1.

Optional Feature:
PPA_SATURATE_EN
- Defined:
  - Adds port in_sat (in, 1), carried through the pipeline.
  - When in_sat = 1 and signed overflow occurs, out_sum clamps: 0x7F..F on positive overflow, 0x80..0 on negative overflow.
  - out_ovf still reports the overflow. out_zero is computed from the clamped value.
- Undefined: port in_sat is absent and all results wrap.

Decomposition:
- Package ppa_pkg holds:
  - typedef pg_t (struct of g, p bits);
  - function clog2_ceil;
  - constant function num_stages(WIDTH, REG_EVERY);
  - function pg_combine(hi, lo) returning pg_t.
- Sub-module ppa_black_cell wraps pg_combine as a single prefix node, instantiated in generate loops.
- Stage registers and handshake logic stay in pipelined_prefix_adder.

Test Plan:
All cases use WIDTH = 32, REG_EVERY = 2 (LAT = 4).
1. A = 0xFFFFFFFF, B = 0x00000001, cin = 0, add, tag = 3 -> 4 cycles after accept: sum = 0x00000000, cout = 1, ovf = 0, zero = 1, tag = 3.
2. A = 0x80000000, B = 0x00000001, sub -> sum = 0x7FFFFFFF, cout = 1, ovf = 1, zero = 0.
3. 8 back-to-back adds i + i (i = 0..7, tag = i), out_ready = 1 -> out_valid high 8 consecutive cycles starting cycle 4; sums 0, 2, ..., 14; tags in order.
4. Stream with out_ready = 0 for 10 cycles -> in_ready low after exactly 4 accepts; outputs stable while stalled; on release all 4 results appear in order, then streaming resumes without loss.
5. 3 operations in flight, rst_n = 0 for one cycle -> no out_valid afterwards; all outputs 0; in_ready = 1 next cycle.
6. PPA_SATURATE_EN defined: A = 0x7FFFFFFF, B = 1, in_sat = 1 -> sum = 0x7FFFFFFF, ovf = 1. Same operation with in_sat = 0 -> sum = 0x80000000, ovf = 1.
